// File: rtl/x_window_buffer.sv
// x_window_buffer: multi-row operand buffer for the matrix-multiply datapath.
// Rows are filled beat-by-beat from the load path (FILL). Once every row is
// full, the block presents a WIN-element window of a selected row and shifts
// all rows together, either rotating or zero-filling (RUN).
module x_window_buffer #(
    parameter int ELEM_W     = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 8,
    parameter int LOAD_ELEMS = 4,
    parameter int WIN        = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [$clog2(ROWS)-1:0]        load_row,
    input  logic [LOAD_ELEMS*ELEM_W-1:0]   load_data,
    output logic                           load_done,
    input  logic                           shift_en,
    input  logic                           shift_mode,
    input  logic [$clog2(ROWS)-1:0]        rd_row,
    output logic [WIN*ELEM_W-1:0]          win_data,
    output logic                           win_valid,
    output logic [$clog2(COLS)-1:0]        shift_cnt,
    output logic                           pass_done
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = $clog2(COLS);
    localparam int FILL_W = $clog2(COLS + 1);
    localparam int BEATS  = COLS / LOAD_ELEMS;
    // When ROWS is a power of two every row index is legal.
    localparam bit ROWS_POW2 = (ROWS == (1 << ROW_W));

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ELEM_W-1:0]     mem_q [ROWS][COLS];
    logic [ELEM_W-1:0]     mem_d [ROWS][COLS];
    logic [FILL_W-1:0]     fill_q [ROWS];
    logic [FILL_W-1:0]     fill_d [ROWS];
    logic [CNT_W-1:0]      shift_cnt_q, shift_cnt_d;
    logic                  pass_done_q, pass_done_d;

    logic [ROWS-1:0]       row_full;
    logic                  load_row_ok;
    logic                  rd_row_ok;
    logic                  load_accept;
    logic                  all_full_d;

    // State register for the FILL/RUN controller.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter RUN on the beat that fills the last row.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_FILL;
        end else if (state_q == ST_FILL && load_accept && all_full_d) begin
            state_d = ST_RUN;
        end
    end

    // Output logic: fill status, load handshake and run indicators.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_full[r] = (fill_q[r] == FILL_W'(COLS));
        end
        load_row_ok = ROWS_POW2 || (int'(load_row) < ROWS);
        rd_row_ok   = ROWS_POW2 || (int'(rd_row) < ROWS);
        load_ready  = (state_q == ST_FILL) && load_row_ok && !row_full[load_row];
        load_accept = load_valid && load_ready;
        load_done   = (state_q == ST_RUN);
        win_valid   = (state_q == ST_RUN);
        shift_cnt   = shift_cnt_q;
        pass_done   = pass_done_q;
    end

    // Datapath next values: clear, beat write in FILL, row shift in RUN.
    always_comb begin
        mem_d       = mem_q;
        fill_d      = fill_q;
        shift_cnt_d = shift_cnt_q;
        pass_done_d = 1'b0;
        if (clr) begin
            for (int r = 0; r < ROWS; r++) begin
                fill_d[r] = '0;
                for (int c = 0; c < COLS; c++) begin
                    mem_d[r][c] = '0;
                end
            end
            shift_cnt_d = '0;
        end else if (state_q == ST_FILL) begin
            for (int r = 0; r < ROWS; r++) begin
                if (load_accept && load_row == ROW_W'(r)) begin
                    // Fill level is always a whole number of beats, so match
                    // it against each beat slot to place the elements.
                    for (int b = 0; b < BEATS; b++) begin
                        if (fill_q[r] == FILL_W'(b * LOAD_ELEMS)) begin
                            for (int i = 0; i < LOAD_ELEMS; i++) begin
                                mem_d[r][b*LOAD_ELEMS+i] = load_data[i*ELEM_W +: ELEM_W];
                            end
                        end
                    end
                    fill_d[r] = fill_q[r] + FILL_W'(LOAD_ELEMS);
                end
            end
        end else if (shift_en) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS - 1; c++) begin
                    mem_d[r][c] = mem_q[r][c+1];
                end
                mem_d[r][COLS-1] = shift_mode ? '0 : mem_q[r][0];
            end
            if (shift_cnt_q == CNT_W'(COLS - 1)) begin
                shift_cnt_d = '0;
                pass_done_d = 1'b1;
            end else begin
                shift_cnt_d = shift_cnt_q + 1'b1;
            end
        end

        all_full_d = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if (fill_d[r] != FILL_W'(COLS)) begin
                all_full_d = 1'b0;
            end
        end
    end

    // Datapath registers: storage, fill counters, shift counter, pass pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the storage array is reset because win_data must read 0
            // out of reset and a reset mid-load must discard partial rows.
            for (int r = 0; r < ROWS; r++) begin
                fill_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
            shift_cnt_q <= '0;
            pass_done_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            mem_q       <= mem_d;
            shift_cnt_q <= shift_cnt_d;
            pass_done_q <= pass_done_d;
        end
    end

    // Window mux: head WIN elements of the selected row, zero if out of range.
    always_comb begin
        win_data = '0;
        if (rd_row_ok) begin
            for (int i = 0; i < WIN; i++) begin
                win_data[i*ELEM_W +: ELEM_W] = mem_q[rd_row][i];
            end
        end
    end

endmodule

// File: tb/tb_x_window_buffer.sv
// Self-checking bench for x_window_buffer: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// plain array model of rows, fill levels and pass counting.
module tb_x_window_buffer;

    localparam int ELEM_W     = 8;
    localparam int ROWS       = 4;
    localparam int COLS       = 8;
    localparam int LOAD_ELEMS = 4;
    localparam int WIN        = 3;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         clr = 1'b0;
    logic                         load_valid = 1'b0;
    logic                         load_ready;
    logic [1:0]                   load_row = '0;
    logic [LOAD_ELEMS*ELEM_W-1:0] load_data = '0;
    logic                         load_done;
    logic                         shift_en = 1'b0;
    logic                         shift_mode = 1'b0;
    logic [1:0]                   rd_row = '0;
    logic [WIN*ELEM_W-1:0]        win_data;
    logic                         win_valid;
    logic [2:0]                   shift_cnt;
    logic                         pass_done;

    x_window_buffer #(
        .ELEM_W(ELEM_W), .ROWS(ROWS), .COLS(COLS),
        .LOAD_ELEMS(LOAD_ELEMS), .WIN(WIN)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_row(load_row), .load_data(load_data), .load_done(load_done),
        .shift_en(shift_en), .shift_mode(shift_mode), .rd_row(rd_row),
        .win_data(win_data), .win_valid(win_valid),
        .shift_cnt(shift_cnt), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: plain arrays and integers.
    int m_mem [ROWS][COLS];
    int m_fill [ROWS];
    bit m_run;
    int m_cnt;
    bit m_pd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++) begin
            m_fill[r] = 0;
            for (int c = 0; c < COLS; c++) m_mem[r][c] = 0;
        end
        m_run = 0;
        m_cnt = 0;
        m_pd  = 0;
    endtask

    // Apply one rising edge worth of behaviour using the current inputs.
    task automatic model_edge();
        int head;
        bit all_full;
        if (clr) begin
            model_clear();
        end else if (!m_run) begin
            m_pd = 0;
            if (load_valid && m_fill[load_row] < COLS) begin
                for (int i = 0; i < LOAD_ELEMS; i++)
                    m_mem[load_row][m_fill[load_row] + i] = int'(load_data[i*ELEM_W +: ELEM_W]);
                m_fill[load_row] += LOAD_ELEMS;
                all_full = 1;
                for (int r = 0; r < ROWS; r++) if (m_fill[r] != COLS) all_full = 0;
                if (all_full) m_run = 1;
            end
        end else begin
            m_pd = 0;
            if (shift_en) begin
                for (int r = 0; r < ROWS; r++) begin
                    head = m_mem[r][0];
                    for (int c = 0; c < COLS - 1; c++) m_mem[r][c] = m_mem[r][c+1];
                    m_mem[r][COLS-1] = shift_mode ? 0 : head;
                end
                m_cnt++;
                if (m_cnt == COLS) begin
                    m_cnt = 0;
                    m_pd  = 1;
                end
            end
        end
    endtask

    function automatic logic [WIN*ELEM_W-1:0] model_win();
        logic [WIN*ELEM_W-1:0] w;
        for (int i = 0; i < WIN; i++) w[i*ELEM_W +: ELEM_W] = 8'(m_mem[rd_row][i]);
        return w;
    endfunction

    task automatic compare_all();
        check("load_ready", 64'(load_ready), 64'(!m_run && m_fill[load_row] < COLS));
        check("load_done",  64'(load_done),  64'(m_run));
        check("win_valid",  64'(win_valid),  64'(m_run));
        check("shift_cnt",  64'(shift_cnt),  64'(m_cnt));
        check("pass_done",  64'(pass_done),  64'(m_pd));
        check("win_data",   64'(win_data),   64'(model_win()));
    endtask

    // Called at a falling edge with inputs already set: check, clock, model.
    task automatic cycle();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [31:0] bdata(input int r, input int k);
        return (k == 0 ? 32'h0302_0100 : 32'h0706_0504) + 32'h1010_1010 * 32'(r);
    endfunction

    task automatic beat(input int r, input logic [31:0] d);
        load_valid = 1'b1;
        load_row   = 2'(r);
        load_data  = d;
        cycle();
        load_valid = 1'b0;
    endtask

    task automatic shift(input bit mode, input int n);
        shift_en   = 1'b1;
        shift_mode = mode;
        repeat (n) cycle();
        shift_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, 64'(load_ready), 64'd1);
        check({tag, "_load_done"},  64'(load_done),  64'd0);
        check({tag, "_win_valid"},  64'(win_valid),  64'd0);
        check({tag, "_win_data"},   64'(win_data),   64'd0);
        check({tag, "_shift_cnt"},  64'(shift_cnt),  64'd0);
        check({tag, "_pass_done"},  64'(pass_done),  64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_clear();

        // Reset state.
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b1;

        // Load with backpressure on row 1.
        beat(1, bdata(1, 0));
        beat(1, bdata(1, 1));
        load_valid = 1'b1;
        load_row   = 2'd1;
        load_data  = 32'hdead_beef;
        rd_row     = 2'd1;
        #1 check("bp_load_ready", 64'(load_ready), 64'd0);
        check("bp_row1_win", 64'(win_data), 64'h12_1110);
        cycle();
        cycle();
        check("bp_row1_kept", 64'(win_data), 64'h12_1110);
        load_row  = 2'd0;
        load_data = bdata(0, 0);
        #1 check("bp_switch_ready", 64'(load_ready), 64'd1);
        cycle();
        beat(0, bdata(0, 1));
        beat(2, bdata(2, 0));
        beat(2, bdata(2, 1));
        beat(3, bdata(3, 0));
        load_valid = 1'b1;
        load_row   = 2'd3;
        load_data  = bdata(3, 1);
        #1 check("pre_last_load_done", 64'(load_done), 64'd0);
        cycle();
        load_valid = 1'b0;
        rd_row     = 2'd2;
        #1 check("post_last_load_done", 64'(load_done), 64'd1);
        check("post_last_win_valid", 64'(win_valid), 64'd1);
        check("row2_window", 64'(win_data), 64'h22_2120);

        // Rotate pass on row 0.
        rd_row = 2'd0;
        shift(1'b0, 1);
        #1 check("rot_shift1", 64'(win_data), 64'h03_0201);
        shift(1'b0, 7);
        #1 check("rot_pass_done", 64'(pass_done), 64'd1);
        check("rot_cnt_wrap", 64'(shift_cnt), 64'd0);
        check("rot_win_back", 64'(win_data), 64'h02_0100);
        cycle();
        check("rot_pass_once", 64'(pass_done), 64'd0);

        // Zero-fill pass on row 0.
        shift(1'b1, 6);
        #1 check("zf_6", 64'(win_data), 64'h00_0706);
        shift(1'b1, 2);
        #1 check("zf_8", 64'(win_data), 64'h00_0000);
        check("zf_pass_done", 64'(pass_done), 64'd1);

        // clr overrides a simultaneous shift.
        shift_en = 1'b1;
        clr      = 1'b1;
        cycle();
        clr      = 1'b0;
        shift_en = 1'b0;
        #1 check("clr_load_done", 64'(load_done), 64'd0);
        check("clr_load_ready", 64'(load_ready), 64'd1);
        check("clr_shift_cnt", 64'(shift_cnt), 64'd0);
        check("clr_win_data", 64'(win_data), 64'd0);

        // Randomized rounds: random interleaved fill, then random run traffic.
        for (int round = 0; round < 6; round++) begin
            n = 0;
            while (!m_run && n < 200) begin
                load_valid = ($urandom_range(0, 3) != 0);
                load_row   = 2'($urandom_range(0, ROWS - 1));
                load_data  = $urandom;
                rd_row     = 2'($urandom_range(0, ROWS - 1));
                shift_en   = $urandom_range(0, 1) == 1;
                cycle();
                n++;
            end
            load_valid = 1'b0;
            shift_en   = 1'b0;
            #1 check("rand_fill_done", 64'(load_done), 64'd1);
            for (int k = 0; k < 150; k++) begin
                shift_en   = ($urandom_range(0, 4) != 0);
                shift_mode = ($urandom_range(0, 3) == 0);
                rd_row     = 2'($urandom_range(0, ROWS - 1));
                load_valid = $urandom_range(0, 1) == 1;
                load_row   = 2'($urandom_range(0, ROWS - 1));
                load_data  = $urandom;
                clr        = (k == 149) || ($urandom_range(0, 199) == 0);
                cycle();
            end
            clr        = 1'b0;
            shift_en   = 1'b0;
            load_valid = 1'b0;
        end

        // Async reset in the middle of a load.
        rd_row = 2'd0;
        beat(0, bdata(0, 0));
        beat(1, bdata(1, 0));
        beat(2, bdata(2, 0));
        #2 rst = 1'b0;
        #1 check_reset_outputs("arst");
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            beat(r, bdata(r, 0));
            if (r < ROWS - 1) begin
                beat(r, bdata(r, 1));
            end else begin
                #1 check("arst_pre_last_done", 64'(load_done), 64'd0);
                beat(r, bdata(r, 1));
            end
        end
        #1 check("arst_reload_done", 64'(load_done), 64'd1);
        check("arst_row0_win", 64'(win_data), 64'h02_0100);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
